// File: rtl/pool_pkg.sv
// Shared definitions for the 2x2 max-pooling engine: APB register offsets,
// STATUS bit positions, FSM states and the signed-byte helpers.
package pool_pkg;

  localparam logic [3:0] ADDR_CTRL   = 4'h0;
  localparam logic [3:0] ADDR_STATUS = 4'h4;
  localparam logic [3:0] ADDR_WIDTH  = 4'h8;
  localparam logic [3:0] ADDR_HEIGHT = 4'hC;

  localparam int STATUS_DONE      = 0;
  localparam int STATUS_BUSY      = 1;
  localparam int STATUS_TLAST_ERR = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EVEN_ROW,
    ST_ODD_ROW,
    ST_DRAIN,
    ST_DONE
  } pool_state_t;

  // Larger of two bytes interpreted as two's-complement int8.
  function automatic logic [7:0] smax8(input logic [7:0] a, input logic [7:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

  // Clamp a signed byte at zero.
  function automatic logic [7:0] relu8(input logic [7:0] a);
    return a[7] ? 8'h00 : a;
  endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// One-row line buffer: simple dual-port register array, one write port and
// one registered read port. Contents are not reset.
module pool_line_buffer #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Write port: store the even-row word at its column.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read port: registered, so the address must lead the use by one cycle.
  always_ff @(posedge clk) begin
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/pool_stream_2x2.sv
// Streaming 2x2 / stride-2 signed int8 max-pooling engine with APB control.
// Optional feature macro: POOL_RELU_EN (fused ReLU on every output byte).
module pool_stream_2x2
  import pool_pkg::*;
#(
  parameter int MAX_WIDTH_WORDS        = 64,
  parameter int C_S00_AXIS_TDATA_WIDTH = 32
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] PADDR,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  input  logic [31:0] S_AXIS_TDATA,
  input  logic [3:0]  S_AXIS_TKEEP,
  input  logic        S_AXIS_TUSER,
  input  logic        S_AXIS_TLAST,
  input  logic        S_AXIS_TVALID,
  output logic        S_AXIS_TREADY,
  output logic [31:0] M_AXIS_TDATA,
  output logic [3:0]  M_AXIS_TKEEP,
  output logic        M_AXIS_TUSER,
  output logic        M_AXIS_TLAST,
  output logic        M_AXIS_TVALID,
  input  logic        M_AXIS_TREADY
);

  localparam int AW = (MAX_WIDTH_WORDS > 1) ? $clog2(MAX_WIDTH_WORDS) : 1;

  pool_state_t state, state_next;
  logic [7:0]  width, col, col_next;
  logic [11:0] row, height;
  logic        done, tlast_err, first_out;
  logic        busy, apb_wr, start_req, start_bad, start_ok, cfg_wr;
  logic        in_hs, last_col, last_row, final_in, emit;
  logic [31:0] buf_rdata;
  logic [7:0]  vmax [4];
  logic [15:0] pooled, lo_half;
  logic        unused_ok;

  assign unused_ok = &{1'b0, PADDR[31:4], PWDATA[31:12], S_AXIS_TKEEP, S_AXIS_TUSER,
                       C_S00_AXIS_TDATA_WIDTH[0]};

  assign busy      = state inside {ST_EVEN_ROW, ST_ODD_ROW, ST_DRAIN};
  assign apb_wr    = PSEL && PENABLE && PWRITE;
  assign start_req = apb_wr && (PADDR[3:0] == ADDR_CTRL) && PWDATA[0];
  assign start_bad = busy || width[0] || (width == 8'd0) || (32'(width) > MAX_WIDTH_WORDS) ||
                     height[0] || (height == 12'd0);
  assign start_ok  = start_req && !start_bad;
  assign cfg_wr    = apb_wr && ((PADDR[3:0] == ADDR_WIDTH) || (PADDR[3:0] == ADDR_HEIGHT));

  assign PREADY  = 1'b1;
  assign PSLVERR = !RESET && ((start_req && start_bad) || (cfg_wr && busy));

  // Combinational APB read decode; zero when not selected or held in reset.
  always_comb begin
    PRDATA = 32'd0;
    if (PSEL && !RESET) begin
      case (PADDR[3:0])
        ADDR_STATUS: PRDATA = {29'd0, tlast_err, busy, done};
        ADDR_WIDTH:  PRDATA = {24'd0, width};
        ADDR_HEIGHT: PRDATA = {20'd0, height};
        default:     PRDATA = 32'd0;
      endcase
    end
  end

  assign S_AXIS_TREADY = ((state == ST_EVEN_ROW) || (state == ST_ODD_ROW)) &&
                         (!M_AXIS_TVALID || M_AXIS_TREADY);
  assign in_hs    = S_AXIS_TVALID && S_AXIS_TREADY;
  assign last_col = (col == width - 8'd1);
  assign last_row = (row == height - 12'd1);
  assign final_in = (state == ST_ODD_ROW) && last_col && last_row;
  assign emit     = in_hs && (state == ST_ODD_ROW) && col[0];
  assign col_next = in_hs ? (last_col ? 8'd0 : col + 8'd1) : col;

  // The read address follows col_next so buffer[col] is ready at the handshake.
  pool_line_buffer #(.DEPTH(MAX_WIDTH_WORDS), .AW(AW)) u_line_buffer (
    .clk   (CLK),
    .we    (in_hs && (state == ST_EVEN_ROW)),
    .waddr (col[AW-1:0]),
    .wdata (S_AXIS_TDATA),
    .raddr (col_next[AW-1:0]),
    .rdata (buf_rdata)
  );

  // Vertical max per byte, then horizontal max of byte pairs (0,1) and (2,3).
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      vmax[i] = smax8(buf_rdata[8*i +: 8], S_AXIS_TDATA[8*i +: 8]);
    end
`ifdef POOL_RELU_EN
    pooled = {relu8(smax8(vmax[2], vmax[3])), relu8(smax8(vmax[0], vmax[1]))};
`else
    pooled = {smax8(vmax[2], vmax[3]), smax8(vmax[0], vmax[1])};
`endif
  end

  // FSM state register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= ST_IDLE;
    else       state <= state_next;
  end

  // FSM next-state logic: two rows per pooled row, then drain the last word.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:     if (start_ok) state_next = ST_EVEN_ROW;
      ST_EVEN_ROW: if (in_hs && last_col) state_next = ST_ODD_ROW;
      ST_ODD_ROW:  if (in_hs && last_col) state_next = last_row ? ST_DRAIN : ST_EVEN_ROW;
      ST_DRAIN:    if (!M_AXIS_TVALID || M_AXIS_TREADY) state_next = ST_DONE;
      ST_DONE:     state_next = start_ok ? ST_EVEN_ROW : ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  // Configuration registers, position counters and status flags.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      width     <= 8'd0;
      height    <= 12'd0;
      col       <= 8'd0;
      row       <= 12'd0;
      done      <= 1'b0;
      tlast_err <= 1'b0;
      first_out <= 1'b0;
    end else begin
      if (apb_wr && !busy && (PADDR[3:0] == ADDR_WIDTH))  width  <= PWDATA[7:0];
      if (apb_wr && !busy && (PADDR[3:0] == ADDR_HEIGHT)) height <= PWDATA[11:0];
      if (start_ok) begin
        col       <= 8'd0;
        row       <= 12'd0;
        done      <= 1'b0;
        tlast_err <= 1'b0;
        first_out <= 1'b1;
      end else begin
        col <= col_next;
        if (in_hs && last_col) row <= final_in ? 12'd0 : row + 12'd1;
        if (in_hs && (S_AXIS_TLAST != final_in)) tlast_err <= 1'b1;
        if (emit) first_out <= 1'b0;
        if ((state == ST_DRAIN) && (state_next == ST_DONE)) done <= 1'b1;
      end
    end
  end

  // Output register: low half parked on even col, word emitted on odd col.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      lo_half       <= 16'd0;
      M_AXIS_TDATA  <= 32'd0;
      M_AXIS_TKEEP  <= 4'd0;
      M_AXIS_TUSER  <= 1'b0;
      M_AXIS_TLAST  <= 1'b0;
      M_AXIS_TVALID <= 1'b0;
    end else begin
      if (in_hs && (state == ST_ODD_ROW) && !col[0]) lo_half <= pooled;
      if (emit) begin
        M_AXIS_TDATA  <= {pooled, lo_half};
        M_AXIS_TKEEP  <= 4'hF;
        M_AXIS_TUSER  <= first_out;
        M_AXIS_TLAST  <= final_in;
        M_AXIS_TVALID <= 1'b1;
      end else if (M_AXIS_TVALID && M_AXIS_TREADY) begin
        M_AXIS_TVALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pool_stream_2x2.sv
// Self-checking bench for pool_stream_2x2: directed frames plus randomized
// data and backpressure against a pixel-level pooling model.
module tb_pool_stream_2x2;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [31:0] S_AXIS_TDATA, M_AXIS_TDATA;
  logic [3:0]  S_AXIS_TKEEP, M_AXIS_TKEEP;
  logic        S_AXIS_TUSER, S_AXIS_TLAST, S_AXIS_TVALID, S_AXIS_TREADY;
  logic        M_AXIS_TUSER, M_AXIS_TLAST, M_AXIS_TVALID, M_AXIS_TREADY;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] words [0:63];
  logic [31:0] exp_q [$];

  always #5 CLK = ~CLK;

  pool_stream_2x2 dut (
    .CLK(CLK), .RESET(RESET),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TKEEP(S_AXIS_TKEEP), .S_AXIS_TUSER(S_AXIS_TUSER),
    .S_AXIS_TLAST(S_AXIS_TLAST), .S_AXIS_TVALID(S_AXIS_TVALID), .S_AXIS_TREADY(S_AXIS_TREADY),
    .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TKEEP(M_AXIS_TKEEP), .M_AXIS_TUSER(M_AXIS_TUSER),
    .M_AXIS_TLAST(M_AXIS_TLAST), .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TREADY(M_AXIS_TREADY)
  );

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apb_write(input logic [31:0] a, input logic [31:0] d, output logic err);
    @(negedge CLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    @(negedge CLK);
    PENABLE = 1'b1;
    #1 err = PSLVERR;
    @(negedge CLK);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge CLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    @(negedge CLK);
    PENABLE = 1'b1;
    #1 d = PRDATA;
    @(negedge CLK);
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  // Reference: pooled pixel = max of its 2x2 window, packed 4 pixels per word.
  function automatic void build_model(input int w, input int h);
    int  pooled [0:255];
    int  pw, m, x;
    byte sb;
    logic [31:0] word;
    exp_q.delete();
    pw = 2 * w;
    for (int r = 0; r < h / 2; r++) begin
      for (int p = 0; p < pw; p++) begin
        m = -128;
        for (int dy = 0; dy < 2; dy++) begin
          for (int dx = 0; dx < 2; dx++) begin
            x  = 2 * p + dx;
            sb = byte'(words[(2 * r + dy) * w + x / 4] >> (8 * (x % 4)));
            if (int'(sb) > m) m = int'(sb);
          end
        end
`ifdef POOL_RELU_EN
        if (m < 0) m = 0;
`endif
        pooled[r * pw + p] = m;
      end
    end
    for (int j = 0; j < (w * h) / 4; j++) begin
      word = {8'(pooled[4*j+3]), 8'(pooled[4*j+2]), 8'(pooled[4*j+1]), 8'(pooled[4*j])};
      exp_q.push_back(word);
    end
  endfunction

  task automatic apply_stimulus(input int w, input int h, input int tlast_idx, input bit rnd,
                                output logic [31:0] first_word);
    logic        e;
    logic [31:0] st, held;
    int          n_in, n_out, in_idx, out_idx, cyc;
    bit          prev_in_fire, prev_stall, in_fire, out_fire;
    build_model(w, h);
    n_in = w * h; n_out = exp_q.size();
    in_idx = 0; out_idx = 0; cyc = 0; prev_in_fire = 0; prev_stall = 0;
    held = 32'd0; first_word = 32'hDEADBEEF;
    apb_write(32'h8, 32'(w), e);  check_output("cfg_width_err", 32'(e), 32'd0);
    apb_write(32'hC, 32'(h), e);  check_output("cfg_height_err", 32'(e), 32'd0);
    apb_write(32'h0, 32'h1, e);   check_output("start_err", 32'(e), 32'd0);
    while (out_idx < n_out && cyc < 2000) begin
      @(negedge CLK);
      cyc++;
      M_AXIS_TREADY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (in_idx < n_in) begin
        if (!S_AXIS_TVALID || prev_in_fire)
          S_AXIS_TVALID = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        S_AXIS_TDATA = words[in_idx];
        S_AXIS_TKEEP = 4'($urandom);
        S_AXIS_TUSER = 1'($urandom);
        S_AXIS_TLAST = (tlast_idx < 0) ? (in_idx == n_in - 1) : (in_idx == tlast_idx);
      end else begin
        S_AXIS_TVALID = 1'b0;
      end
      #1;
      if (prev_stall) begin
        check_output("hold_valid", 32'(M_AXIS_TVALID), 32'd1);
        check_output("hold_data", M_AXIS_TDATA, held);
      end
      if (M_AXIS_TVALID && !M_AXIS_TREADY)
        check_output("bp_tready", 32'(S_AXIS_TREADY), 32'd0);
      in_fire  = S_AXIS_TVALID && S_AXIS_TREADY;
      out_fire = M_AXIS_TVALID && M_AXIS_TREADY;
      if (out_fire) begin
        if (out_idx == 0) first_word = M_AXIS_TDATA;
        check_output("out_data", M_AXIS_TDATA, exp_q[out_idx]);
        check_output("out_user", 32'(M_AXIS_TUSER), 32'(out_idx == 0));
        check_output("out_last", 32'(M_AXIS_TLAST), 32'(out_idx == n_out - 1));
        check_output("out_keep", 32'(M_AXIS_TKEEP), 32'hF);
        out_idx++;
      end
      prev_stall = M_AXIS_TVALID && !M_AXIS_TREADY;
      held = M_AXIS_TDATA;
      if (in_fire) in_idx++;
      prev_in_fire = in_fire;
    end
    @(negedge CLK);
    S_AXIS_TVALID = 1'b0;
    M_AXIS_TREADY = 1'b1;
    check_output("in_count", 32'(in_idx), 32'(n_in));
    check_output("out_count", 32'(out_idx), 32'(n_out));
    st = 32'd0;
    for (int k = 0; k < 10; k++) begin
      apb_read(32'h4, st);
      if (st[0]) break;
    end
    check_output("status", st, (tlast_idx >= 0) ? 32'h5 : 32'h1);
  endtask

  initial begin
    logic [31:0] rd, fw;
    logic        e;
    int          fed;
    int          bad_w [5] = '{3, 0, 66, 2, 2};
    int          bad_h [5] = '{2, 2, 2, 3, 0};

    RESET = 1'b1; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = 0; PWDATA = 0;
    S_AXIS_TDATA = 0; S_AXIS_TKEEP = 0; S_AXIS_TUSER = 0; S_AXIS_TLAST = 0;
    S_AXIS_TVALID = 0; M_AXIS_TREADY = 1;

    // Reset values
    repeat (2) @(negedge CLK);
    #1;
    check_output("rst_tvalid", 32'(M_AXIS_TVALID), 32'd0);
    check_output("rst_tdata", M_AXIS_TDATA, 32'd0);
    check_output("rst_tkeep", 32'(M_AXIS_TKEEP), 32'd0);
    check_output("rst_tuser_tlast", {30'd0, M_AXIS_TUSER, M_AXIS_TLAST}, 32'd0);
    check_output("rst_s_tready", 32'(S_AXIS_TREADY), 32'd0);
    check_output("rst_apb", {PRDATA[30:0], PSLVERR}, 32'd0);
    check_output("rst_pready", 32'(PREADY), 32'd1);
    @(negedge CLK);
    RESET = 1'b0;
    apb_read(32'h4, rd); check_output("rst_status", rd, 32'd0);
    apb_read(32'h8, rd); check_output("rst_width", rd, 32'd0);
    apb_read(32'hC, rd); check_output("rst_height", rd, 32'd0);

    // Basic frame
    words[0] = 32'h04030201; words[1] = 32'h08070605;
    words[2] = 32'h0C0B0A09; words[3] = 32'h100F0E0D;
    apply_stimulus(2, 2, -1, 1'b0, fw);
    check_output("basic_word", fw, 32'h100E0C0A);

    // Illegal configurations: start rejected, nothing else changes
    for (int i = 0; i < 5; i++) begin
      apb_write(32'h8, 32'(bad_w[i]), e);
      apb_write(32'hC, 32'(bad_h[i]), e);
      apb_write(32'h0, 32'h1, e);
      check_output("illegal_pslverr", 32'(e), 32'd1);
      repeat (2) @(negedge CLK);
      #1 check_output("illegal_tready", 32'(S_AXIS_TREADY), 32'd0);
      apb_read(32'h4, rd);
      check_output("illegal_status", rd, 32'h1);
    end
    apb_read(32'h8, rd); check_output("width_readback", rd, 32'd2);

    // Negatives
    words[0] = 32'h80808080; words[1] = 32'h80808080;
    words[2] = 32'hFFFFFFFF; words[3] = 32'hFFFFFFFF;
    apply_stimulus(2, 2, -1, 1'b0, fw);
`ifdef POOL_RELU_EN
    check_output("neg_word", fw, 32'h00000000);
`else
    check_output("neg_word", fw, 32'hFFFFFFFF);
`endif

    // Backpressure with random data
    for (int i = 0; i < 16; i++) words[i] = $urandom;
    apply_stimulus(4, 4, -1, 1'b1, fw);

    // TLAST mismatch
    for (int i = 0; i < 4; i++) words[i] = $urandom;
    apply_stimulus(2, 2, 1, 1'b1, fw);

    // Mid-frame reset with a pending output word
    for (int i = 0; i < 8; i++) words[i] = $urandom;
    apb_write(32'h8, 32'd4, e);
    apb_write(32'hC, 32'd2, e);
    apb_write(32'h0, 32'h1, e);
    check_output("mid_start_err", 32'(e), 32'd0);
    apb_write(32'h0, 32'h1, e);
    check_output("busy_start_err", 32'(e), 32'd1);
    apb_write(32'h8, 32'd6, e);
    check_output("busy_cfg_err", 32'(e), 32'd1);
    apb_read(32'h8, rd); check_output("busy_width_kept", rd, 32'd4);
    apb_read(32'h4, rd); check_output("busy_status", rd, 32'h2);
    M_AXIS_TREADY = 1'b0;
    fed = 0;
    for (int c = 0; c < 50 && fed < 6; c++) begin
      @(negedge CLK);
      S_AXIS_TVALID = 1'b1; S_AXIS_TDATA = words[fed]; S_AXIS_TLAST = 1'b0;
      #1;
      if (S_AXIS_TREADY) fed++;
    end
    @(negedge CLK);
    S_AXIS_TVALID = 1'b0;
    check_output("mid_fed", 32'(fed), 32'd6);
    #1 check_output("mid_pending", 32'(M_AXIS_TVALID), 32'd1);
    RESET = 1'b1;
    #1;
    check_output("abort_tvalid", 32'(M_AXIS_TVALID), 32'd0);
    check_output("abort_tdata", M_AXIS_TDATA, 32'd0);
    check_output("abort_tkeep", 32'(M_AXIS_TKEEP), 32'd0);
    check_output("abort_s_tready", 32'(S_AXIS_TREADY), 32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    M_AXIS_TREADY = 1'b1;
    apb_read(32'h4, rd); check_output("abort_status", rd, 32'd0);

    // Fresh frame after reset
    for (int i = 0; i < 8; i++) words[i] = $urandom;
    apply_stimulus(2, 4, -1, 1'b1, fw);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
